// File: rtl/mc_control_fsm.sv
// Main control FSM of the multi-cycle RV32I core: sequences fetch/decode/execute/
// memory/writeback over the shared datapath and traps illegal opcodes and memory timeouts.
module mc_control_fsm #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       br_taken,
    input  logic       mem_ready,
    output logic       pc_we,
    output logic       ir_we,
    output logic       mem_en,
    output logic       mem_wr,
    output logic       addr_sel,
    output logic       rf_we,
    output logic [1:0] wb_sel,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       instr_retired,
    output logic       fault,
    output logic [1:0] fault_cause
);

    localparam logic [3:0] S_FETCH   = 4'd0;
    localparam logic [3:0] S_DECODE  = 4'd1;
    localparam logic [3:0] S_EXEC_R  = 4'd2;
    localparam logic [3:0] S_EXEC_I  = 4'd3;
    localparam logic [3:0] S_MEM_ADR = 4'd4;
    localparam logic [3:0] S_MEM_RD  = 4'd5;
    localparam logic [3:0] S_MEM_WB  = 4'd6;
    localparam logic [3:0] S_MEM_WR  = 4'd7;
    localparam logic [3:0] S_ALU_WB  = 4'd8;
    localparam logic [3:0] S_BRANCH  = 4'd9;
    localparam logic [3:0] S_JAL     = 4'd10;
    localparam logic [3:0] S_FAULT   = 4'd11;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(MEM_TIMEOUT - 1);

    logic [3:0]       state, state_nxt;
    logic [1:0]       cause, cause_nxt;
    logic [CNT_W-1:0] wait_cnt;
    logic             mem_state, waiting, timeout;

    // funct3/funct7b5 steer the ALU decoder outside this FSM; they never affect sequencing.
    logic unused_ir;
    assign unused_ir = ^{funct3, funct7b5};

    assign mem_state = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
    assign waiting   = mem_state && !mem_ready;
    // The MEM_TIMEOUT-th consecutive wait cycle is the last one tolerated.
    assign timeout   = waiting && (wait_cnt == LAST_WAIT);

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        state_nxt = state;
        cause_nxt = cause;
        if (timeout) begin
            state_nxt = S_FAULT;
            cause_nxt = 2'b10;
        end else begin
            case (state)
                S_FETCH:   if (mem_ready) state_nxt = S_DECODE;
                S_DECODE: begin
                    case (opcode)
                        OP_R:              state_nxt = S_EXEC_R;
                        OP_I:              state_nxt = S_EXEC_I;
                        OP_LOAD, OP_STORE: state_nxt = S_MEM_ADR;
                        OP_BRANCH:         state_nxt = S_BRANCH;
                        OP_JAL:            state_nxt = S_JAL;
                        default: begin
                            state_nxt = S_FAULT;
                            cause_nxt = 2'b01;
                        end
                    endcase
                end
                S_EXEC_R, S_EXEC_I: state_nxt = S_ALU_WB;
                S_MEM_ADR: state_nxt = (opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
                S_MEM_RD:  if (mem_ready) state_nxt = S_MEM_WB;
                S_MEM_WR:  if (mem_ready) state_nxt = S_FETCH;
                S_MEM_WB, S_ALU_WB, S_BRANCH, S_JAL: state_nxt = S_FETCH;
                S_FAULT:   state_nxt = S_FAULT;
                default:   state_nxt = S_FAULT;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= S_FETCH;
            cause    <= 2'b00;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            cause    <= cause_nxt;
            wait_cnt <= waiting ? wait_cnt + 1'b1 : '0;
        end
    end

    // Outputs are decoded from state; everything stays low while rst is held.
    always_comb begin
        pc_we         = 1'b0;
        ir_we         = 1'b0;
        mem_en        = 1'b0;
        mem_wr        = 1'b0;
        addr_sel      = 1'b0;
        rf_we         = 1'b0;
        wb_sel        = 2'b00;
        alu_src_a     = 2'b00;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        instr_retired = 1'b0;
        fault         = 1'b0;
        fault_cause   = 2'b00;
        if (rst) begin
            case (state)
                S_FETCH: begin
                    mem_en    = 1'b1;
                    alu_src_b = 2'b10;
                    ir_we     = mem_ready;
                    pc_we     = mem_ready;
                end
                S_DECODE: begin
                    alu_src_a = 2'b10;
                    alu_src_b = 2'b01;
                end
                S_EXEC_R: begin
                    alu_src_a = 2'b01;
                    alu_op    = 2'b10;
                end
                S_EXEC_I: begin
                    alu_src_a = 2'b01;
                    alu_src_b = 2'b01;
                    alu_op    = 2'b10;
                end
                S_MEM_ADR: begin
                    alu_src_a = 2'b01;
                    alu_src_b = 2'b01;
                end
                S_MEM_RD: begin
                    mem_en   = 1'b1;
                    addr_sel = 1'b1;
                end
                S_MEM_WB: begin
                    rf_we         = 1'b1;
                    wb_sel        = 2'b01;
                    instr_retired = 1'b1;
                end
                S_MEM_WR: begin
                    mem_en        = 1'b1;
                    mem_wr        = 1'b1;
                    addr_sel      = 1'b1;
                    instr_retired = mem_ready;
                end
                S_ALU_WB: begin
                    rf_we         = 1'b1;
                    instr_retired = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a     = 2'b01;
                    alu_op        = 2'b01;
                    pc_we         = br_taken;
                    instr_retired = 1'b1;
                end
                S_JAL: begin
                    rf_we         = 1'b1;
                    wb_sel        = 2'b10;
                    pc_we         = 1'b1;
                    instr_retired = 1'b1;
                end
                S_FAULT: begin
                    fault       = 1'b1;
                    fault_cause = cause;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: builds the expected per-cycle output trace of each
// instruction from its class and memory wait counts, then replays it on the DUT.
module tb_mc_control_fsm;

    localparam int TIMEOUT = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [6:0] opcode = '0;
    logic [2:0] funct3 = '0;
    logic       funct7b5 = 1'b0;
    logic       br_taken = 1'b0;
    logic       mem_ready = 1'b0;
    logic       pc_we, ir_we, mem_en, mem_wr, addr_sel, rf_we, instr_retired, fault;
    logic [1:0] wb_sel, alu_src_a, alu_src_b, alu_op, fault_cause;

    always #5 clk = ~clk;

    mc_control_fsm #(.MEM_TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
        .br_taken(br_taken), .mem_ready(mem_ready), .pc_we(pc_we), .ir_we(ir_we),
        .mem_en(mem_en), .mem_wr(mem_wr), .addr_sel(addr_sel), .rf_we(rf_we),
        .wb_sel(wb_sel), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .instr_retired(instr_retired), .fault(fault), .fault_cause(fault_cause)
    );

    typedef struct packed {
        logic       pc_we, ir_we, mem_en, mem_wr, addr_sel, rf_we;
        logic [1:0] wb_sel, alu_src_a, alu_src_b, alu_op;
        logic       retired, fault;
        logic [1:0] fault_cause;
    } outs_t;

    typedef struct {
        logic       rst;
        logic [6:0] opcode;
        logic       mem_ready;
        logic       br_taken;
        outs_t      exp;
    } cyc_t;

    typedef enum {K_R, K_I, K_LW, K_SW, K_BR, K_JAL, K_ILL} kind_t;

    outs_t act;
    assign act = {pc_we, ir_we, mem_en, mem_wr, addr_sel, rf_we, wb_sel, alu_src_a,
                  alu_src_b, alu_op, instr_retired, fault, fault_cause};

    cyc_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc_no   = 0;

    task automatic check(input string name, input logic [31:0] a, input logic [31:0] e);
        n_checks++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: actual=%h expected=%h", name, a, e);
        end
    endtask

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    function automatic logic [6:0] r7();
        return 7'($urandom);
    endfunction

    function automatic bit is_legal(input logic [6:0] op);
        return op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1101111};
    endfunction

    function automatic logic [6:0] op_of(input kind_t k);
        logic [6:0] op;
        case (k)
            K_R:     op = 7'b0110011;
            K_I:     op = 7'b0010011;
            K_LW:    op = 7'b0000011;
            K_SW:    op = 7'b0100011;
            K_BR:    op = 7'b1100011;
            K_JAL:   op = 7'b1101111;
            default: begin
                op = r7();
                while (is_legal(op)) op = r7();
            end
        endcase
        return op;
    endfunction

    task automatic push(input logic r, input logic [6:0] op, input logic mr, input logic bt,
                        input outs_t e);
        cyc_t c;
        c.rst = r; c.opcode = op; c.mem_ready = mr; c.br_taken = bt; c.exp = e;
        q.push_back(c);
    endtask

    task automatic reset_phase(input int n);
        for (int i = 0; i < n; i++) push(1'b0, r7(), rb(), rb(), '0);
    endtask

    task automatic fault_phase(input logic [1:0] cause, input int n);
        outs_t e;
        e = '0; e.fault = 1'b1; e.fault_cause = cause;
        for (int i = 0; i < n; i++) push(1'b1, r7(), rb(), rb(), e);
    endtask

    // A memory access with `waits` not-ready cycles; the TIMEOUT-th wait ends in FAULT.
    task automatic mem_phase(input outs_t e, input logic [6:0] op, input int waits,
                             input bit retire_on_ready, output bit faulted);
        outs_t d;
        int    n;
        n = (waits > TIMEOUT) ? TIMEOUT : waits;
        for (int i = 0; i < n; i++) push(1'b1, op, 1'b0, rb(), e);
        faulted = (waits >= TIMEOUT);
        if (faulted) begin
            fault_phase(2'b10, $urandom_range(1, 4));
        end else begin
            d = e;
            if (e.ir_we === 1'bx) d = e;
            if (retire_on_ready) d.retired = 1'b1;
            if (e.mem_en && !e.addr_sel) begin
                d.ir_we = 1'b1;
                d.pc_we = 1'b1;
            end
            push(1'b1, op, 1'b1, rb(), d);
        end
    endtask

    task automatic instr(input kind_t k, input int fw, input int mw, input logic bt,
                         output bit faulted);
        outs_t      e;
        logic [6:0] op;
        op = op_of(k);
        e = '0; e.mem_en = 1'b1; e.alu_src_b = 2'b10;
        mem_phase(e, r7(), fw, 1'b0, faulted);
        if (faulted) return;
        e = '0; e.alu_src_a = 2'b10; e.alu_src_b = 2'b01;
        push(1'b1, op, rb(), rb(), e);
        case (k)
            K_R, K_I: begin
                e = '0; e.alu_src_a = 2'b01; e.alu_op = 2'b10;
                if (k == K_I) e.alu_src_b = 2'b01;
                push(1'b1, op, rb(), rb(), e);
                e = '0; e.rf_we = 1'b1; e.retired = 1'b1;
                push(1'b1, op, rb(), rb(), e);
            end
            K_LW, K_SW: begin
                e = '0; e.alu_src_a = 2'b01; e.alu_src_b = 2'b01;
                push(1'b1, op, rb(), rb(), e);
                e = '0; e.mem_en = 1'b1; e.addr_sel = 1'b1; e.mem_wr = (k == K_SW);
                mem_phase(e, op, mw, k == K_SW, faulted);
                if (!faulted && k == K_LW) begin
                    e = '0; e.rf_we = 1'b1; e.wb_sel = 2'b01; e.retired = 1'b1;
                    push(1'b1, op, rb(), rb(), e);
                end
            end
            K_BR: begin
                e = '0; e.alu_src_a = 2'b01; e.alu_op = 2'b01; e.pc_we = bt; e.retired = 1'b1;
                push(1'b1, op, rb(), bt, e);
            end
            K_JAL: begin
                e = '0; e.rf_we = 1'b1; e.wb_sel = 2'b10; e.pc_we = 1'b1; e.retired = 1'b1;
                push(1'b1, op, rb(), rb(), e);
            end
            default: begin
                fault_phase(2'b01, $urandom_range(1, 5));
                faulted = 1'b1;
            end
        endcase
    endtask

    // Drive each cycle's inputs just after the rising edge, compare on the falling edge.
    task automatic run_queue();
        cyc_t c;
        while (q.size() > 0) begin
            c = q.pop_front();
            @(posedge clk);
            #1;
            rst = c.rst; opcode = c.opcode; mem_ready = c.mem_ready; br_taken = c.br_taken;
            funct3 = 3'($urandom); funct7b5 = rb();
            @(negedge clk);
            check($sformatf("cycle%0d_outputs", cyc_no), act, c.exp);
            cyc_no++;
        end
    endtask

    task automatic truncate_and_reset(input int cut);
        while (q.size() > cut) void'(q.pop_back());
        reset_phase($urandom_range(1, 2));
    endtask

    function automatic int wait_pick();
        int r;
        r = $urandom_range(0, 19);
        if (r < 16) return r % 4;
        return (r < 18) ? TIMEOUT - 1 : TIMEOUT;
    endfunction

    initial begin
        bit    f;
        int    s;
        kind_t k;

        // 1: reset then ADD with zero-wait memory
        reset_phase(3);
        s = q.size();
        instr(K_R, 0, 0, 1'b0, f);
        check("pin_add_len", q.size() - s, 4);
        check("pin_add_rfwe_c4", q[s+3].exp.rf_we, 1);
        check("pin_add_ret_c4", q[s+3].exp.retired, 1);
        run_queue();

        // 2: LW with three wait cycles in MEM_RD
        s = q.size();
        instr(K_LW, 0, 3, 1'b0, f);
        check("pin_lw_len", q.size() - s, 8);
        check("pin_lw_wb", {q[s+7].exp.rf_we, q[s+7].exp.wb_sel}, 3'b101);
        check("pin_lw_rd_norf", q[s+6].exp.rf_we, 0);
        run_queue();

        // 3: taken BEQ then not-taken BNE
        s = q.size();
        instr(K_BR, 0, 0, 1'b1, f);
        check("pin_beq_len", q.size() - s, 3);
        check("pin_beq_pcwe", q[s+2].exp.pc_we, 1);
        s = q.size();
        instr(K_BR, 0, 0, 1'b0, f);
        check("pin_bne_pcwe", q[s+2].exp.pc_we, 0);
        run_queue();

        // 4: illegal opcode traps after DECODE and holds for 20 cycles
        s = q.size();
        instr(K_ILL, 0, 0, 1'b0, f);
        while (q.size() > s + 3) void'(q.pop_back());
        fault_phase(2'b01, 19);
        run_queue();
        check("t4_dut_fault", fault, 1);
        check("t4_dut_cause", fault_cause, 2'b01);
        reset_phase(1);
        instr(K_JAL, 0, 0, 1'b0, f);
        run_queue();

        // 5: fetch never completes -> FAULT after TIMEOUT cycles, cause 10
        s = q.size();
        instr(K_R, TIMEOUT, 0, 1'b0, f);
        check("pin_to_fetch_last", q[s+TIMEOUT-1].exp.fault, 0);
        check("pin_to_fault", q[s+TIMEOUT].exp.fault, 1);
        run_queue();
        check("t5_dut_cause", fault_cause, 2'b10);
        check("t5_dut_irwe", ir_we, 0);
        reset_phase(2);

        // 6: SW aborted by reset while waiting in MEM_WR
        s = q.size();
        instr(K_SW, 0, 2, 1'b0, f);
        truncate_and_reset(s + 4);
        check("pin_sw_abort_zero", q[s+4].exp, 0);
        instr(K_I, 1, 0, 1'b0, f);
        run_queue();

        // Random instruction stream with random waits, ignored inputs and aborts
        for (int n = 0; n < 300; n++) begin
            k = kind_t'($urandom_range(0, 13) < 13 ? $urandom_range(0, 5) : 6);
            s = q.size();
            instr(k, wait_pick(), wait_pick(), rb(), f);
            if (f) reset_phase($urandom_range(1, 3));
            else if ($urandom_range(0, 19) == 0) truncate_and_reset($urandom_range(s, q.size() - 1));
            run_queue();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
